// File: rtl/phy_tx_sched_pkg.sv
// Shared types and constants for the PHY_TX word scheduler.
package phy_tx_sched_pkg;

  typedef enum logic [1:0] {
    TRAIN,
    IDLE,
    GRANT0,
    GRANT1
  } sched_state_e;

  localparam logic [31:0] COM_WORD = 32'hBCBC_BCBC;

endpackage

// File: rtl/phy_tx_rr_arb.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to the
// requester named by i_ptr. Purely combinational; the pointer lives in the caller.
module phy_tx_rr_arb (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_grant and no latch is inferred.
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = i_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/phy_tx_scheduler.sv
// Shares the PHY_TX word input between two packet sources with round-robin grants.
// Define PHY_TX_SCHED_TRAIN_EN to send NUM_TS COM training words before link-up.
module phy_tx_scheduler
  import phy_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_TS    = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic [31:0] req_data_0,
  input  logic        req_valid_0,
  input  logic        req_last_0,
  output logic        req_ready_0,
  input  logic [31:0] req_data_1,
  input  logic        req_valid_1,
  input  logic        req_last_1,
  output logic        req_ready_1,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        link_up
);

  localparam int unsigned        BURST_W    = $clog2(BURST_MAX + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

  sched_state_e       r_state;
  logic               r_ptr;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [31:0]        r_tx_data;
  logic               r_tx_valid;
  logic               r_link_up;

  logic [1:0]         w_grant;
  logic               w_xfer;
  logic               w_last;
  logic [31:0]        w_data;

`ifdef PHY_TX_SCHED_TRAIN_EN
  localparam int unsigned        TRAIN_W     = $clog2(NUM_TS + 1);
  localparam logic [TRAIN_W-1:0] TRAIN_DONE  = TRAIN_W'(NUM_TS);
  localparam sched_state_e       RESET_STATE = TRAIN;
  logic [TRAIN_W-1:0]            r_train_cnt;
`else
  localparam sched_state_e       RESET_STATE = IDLE;
  logic                          w_unused_num_ts;
  assign w_unused_num_ts = (NUM_TS == 0);
`endif

  phy_tx_rr_arb u_arb (
    .i_req   ({req_valid_1, req_valid_0}),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Ready is a pure decode of the grant state, so it is low whenever reset holds the FSM out of GRANTx.
  assign req_ready_0 = (r_state == GRANT0);
  assign req_ready_1 = (r_state == GRANT1);
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign link_up     = r_link_up;

  always_comb begin
    w_xfer = 1'b0;
    w_data = req_data_0;
    w_last = req_last_0;
    if (r_state == GRANT1) begin
      w_xfer = req_valid_1;
      w_data = req_data_1;
      w_last = req_last_1;
    end else if (r_state == GRANT0) begin
      w_xfer = req_valid_0;
    end
  end

  // NOTE: every register here is assigned with <= so all of them update from pre-edge values.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      r_state     <= RESET_STATE;
      r_ptr       <= 1'b0;
      r_burst_cnt <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_link_up   <= 1'b0;
`ifdef PHY_TX_SCHED_TRAIN_EN
      r_train_cnt <= '0;
`endif
    end else begin
`ifndef PHY_TX_SCHED_TRAIN_EN
      r_link_up <= 1'b1;
`endif
      case (r_state)
`ifdef PHY_TX_SCHED_TRAIN_EN
        TRAIN: begin
          if (r_train_cnt == TRAIN_DONE) begin
            r_train_cnt <= '0;
            r_tx_valid  <= 1'b0;
            r_link_up   <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_train_cnt <= r_train_cnt + TRAIN_W'(1);
            r_tx_data   <= COM_WORD;
            r_tx_valid  <= 1'b1;
          end
        end
`endif
        IDLE: begin
          r_tx_valid <= 1'b0;
          if (w_grant[0]) begin
            r_state <= GRANT0;
          end else if (w_grant[1]) begin
            r_state <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          r_tx_valid <= w_xfer;
          if (w_xfer) begin
            r_tx_data <= w_data;
            // A burst cut short keeps no packet state; the rest goes out on the next grant.
            if (w_last || (r_burst_cnt == BURST_LAST)) begin
              r_burst_cnt <= '0;
              r_ptr       <= (r_state == GRANT0);
              r_state     <= IDLE;
            end else begin
              r_burst_cnt <= r_burst_cnt + BURST_W'(1);
            end
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule
